// File: rtl/parameter_def.sv
// rtl/parameter_def.sv - shared constants, state type and Gray slicer for the QAM decision block
package parameter_def;

  localparam int DEMULT_WIDTH = 13;

  localparam logic [1:0] GRAY_POS_OUTER = 2'b10;
  localparam logic [1:0] GRAY_POS_INNER = 2'b11;
  localparam logic [1:0] GRAY_NEG_INNER = 2'b01;
  localparam logic [1:0] GRAY_NEG_OUTER = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DUMP  = 2'd2
  } qam_state_e;

  // Four-level decision on one accumulated rail; zero belongs to the positive inner level.
  function automatic logic [1:0] gray_slice(input logic signed [31:0] sum,
                                            input logic signed [31:0] thresh);
    if (sum >= thresh)       return GRAY_POS_OUTER;
    else if (sum >= 0)       return GRAY_POS_INNER;
    else if (sum >= -thresh) return GRAY_NEG_INNER;
    else                     return GRAY_NEG_OUTER;
  endfunction

endpackage

// File: rtl/qam_internal_port.sv
// rtl/qam_internal_port.sv - demultiplier-to-decision sample bus
interface qam_internal_port;
  import parameter_def::*;

  logic                           valid;
  logic signed [DEMULT_WIDTH-1:0] i;
  logic signed [DEMULT_WIDTH-1:0] q;

  modport pin (input valid, input i, input q);
  modport drv (output valid, output i, output q);
endinterface

// File: rtl/qam_sym_fifo.sv
// rtl/qam_sym_fifo.sv - two-entry symbol FIFO; a pop frees its slot for a same-cycle push
module qam_sym_fifo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'd2);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/qam_symbol_decision.sv
// rtl/qam_symbol_decision.sv - integrate-and-dump of SPS samples per rail, Gray slicing
// into 2-bit levels, and buffering of the 4-bit symbols behind a valid/ready handshake.
module qam_symbol_decision
  import parameter_def::*;
#(
  parameter int SPS    = 16,
  parameter int THRESH = 2 ** (DEMULT_WIDTH + $clog2(SPS) - 3)
) (
  input  logic              axi_clk,
  input  logic              axi_rstn,
  qam_internal_port.pin     demult,
  output logic [3:0]        sym_data,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [7:0]        abort_cnt,
  output logic              overrun
);

  localparam int ACC_W = DEMULT_WIDTH + $clog2(SPS);
  localparam int CNT_W = $clog2(SPS) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST_M1 = CNT_W'(SPS - 1);

  qam_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              abort_cnt_q, abort_cnt_d;
  logic                    overrun_q, overrun_d;
  logic                    push_q, push_d;
  logic [3:0]              push_data_q, push_data_d;

  logic                    load_smp, add_smp, abort_smp, dump;
  logic signed [ACC_W-1:0] ext_i, ext_q;
  logic                    fifo_full, fifo_empty, pop;

  assign ext_i = {{(ACC_W-DEMULT_WIDTH){demult.i[DEMULT_WIDTH-1]}}, demult.i};
  assign ext_q = {{(ACC_W-DEMULT_WIDTH){demult.q[DEMULT_WIDTH-1]}}, demult.q};

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (demult.valid) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (!demult.valid)             state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST_M1) state_d = ST_DUMP;
      end
      ST_DUMP:  state_d = demult.valid ? ST_ACCUM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A sample seen outside ACCUM always opens a new symbol, which is what makes DUMP gapless.
  always_comb begin
    load_smp  = demult.valid && (state_q != ST_ACCUM);
    add_smp   = demult.valid && (state_q == ST_ACCUM);
    abort_smp = !demult.valid && (state_q == ST_ACCUM);
    dump      = (state_q == ST_DUMP);
  end

  assign pop = sym_valid && sym_ready;

  always_comb begin
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    cnt_d       = cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (load_smp) begin
      acc_i_d = ext_i;
      acc_q_d = ext_q;
      cnt_d   = CNT_ONE;
    end else if (add_smp) begin
      acc_i_d = acc_i_q + ext_i;
      acc_q_d = acc_q_q + ext_q;
      cnt_d   = cnt_q + CNT_ONE;
    end else if (abort_smp || dump) begin
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
    end
    if (abort_smp && (abort_cnt_q != 8'hFF)) abort_cnt_d = abort_cnt_q + 8'd1;
    push_d      = dump;
    push_data_d = {gray_slice(32'(acc_i_q), THRESH), gray_slice(32'(acc_q_q), THRESH)};
    overrun_d   = overrun_q | (push_q & fifo_full & ~pop);
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      abort_cnt_q <= '0;
      overrun_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      abort_cnt_q <= abort_cnt_d;
      overrun_q   <= overrun_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  qam_sym_fifo #(.W(4)) u_fifo (
    .clk       (axi_clk),
    .rst_n     (axi_rstn),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (pop),
    .pop_data  (sym_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sym_valid = !fifo_empty;
  assign abort_cnt = abort_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_qam_symbol_decision.sv
// tb/tb_qam_symbol_decision.sv - bench for qam_symbol_decision at SPS=4, THRESH=64
module tb_qam_symbol_decision;

  logic       clk;
  logic       rstn;
  logic [3:0] sym_data;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] abort_cnt;
  logic       overrun;

  qam_internal_port dm();

  qam_symbol_decision #(.SPS(4), .THRESH(64)) dut (
    .axi_clk   (clk),
    .axi_rstn  (rstn),
    .demult    (dm),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .abort_cnt (abort_cnt),
    .overrun   (overrun)
  );

  typedef struct {
    int         sum_i;
    int         sum_q;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake pops the oldest expected symbol.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sym_valid && sym_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_symbol: got %b expected none", sym_data);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (sym_data !== e) begin
            n_bad++;
            $display("FAIL sym_order: got %b expected %b", sym_data, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_sample(input int i, input int q);
    @(negedge clk);
    dm.valid = 1'b1;
    dm.i     = 13'(i);
    dm.q     = 13'(q);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dm.valid = 1'b0;
      @(posedge clk);
    end
  endtask

  // Splits a target sum over four samples; any remainder rides on the first one.
  task automatic drive_symbol(input int si, input int sq);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive_sample(si - 3 * (si / 4), sq - 3 * (sq / 4));
      else        drive_sample(si / 4, sq / 4);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d symbols pending expected 0", name, exp_q.size());
    end
    idle(4);
  endtask

  initial begin
    vecs[0] = '{160,    -40,    4'b1001};
    vecs[1] = '{0,      -64,    4'b1101};
    vecs[2] = '{63,     -65,    4'b1100};
    vecs[3] = '{-1,     64,     4'b0110};
    vecs[4] = '{400,    400,    4'b1010};
    vecs[5] = '{-16384, -16384, 4'b0000};
    vecs[6] = '{64,     63,     4'b1011};
    vecs[7] = '{-65,    -64,    4'b0001};
    vecs[8] = '{-64,    0,      4'b0111};
    vecs[9] = '{-16384, 16380,  4'b0010};

    rstn = 1'b0; sym_ready = 1'b1;
    dm.valid = 1'b0; dm.i = '0; dm.q = '0;
    repeat (3) @(negedge clk);
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_data",  int'(sym_data),  0);
    check("rst_abort_cnt", int'(abort_cnt), 0);
    check("rst_overrun",   int'(overrun),   0);
    rstn = 1'b1;

    // Single symbol and its latency.
    exp_q.push_back(4'b1001);
    drive_symbol(160, -40);
    @(negedge clk); dm.valid = 1'b0; #1;
    check("lat_edge0", int'(sym_valid), 0);
    @(negedge clk); #1;
    check("lat_edge1", int'(sym_valid), 0);
    @(negedge clk); #1;
    check("lat_edge2", int'(sym_valid), 1);
    wait_drain("drain_single");

    // Back-to-back table, including thresholds and extremes.
    foreach (vecs[n]) begin
      exp_q.push_back(vecs[n].exp);
      drive_symbol(vecs[n].sum_i, vecs[n].sum_q);
    end
    idle(1);
    wait_drain("drain_table");

    // Partial symbol aborted, then a full one.
    drive_sample(30, 30);
    drive_sample(30, 30);
    idle(1);
    exp_q.push_back(4'b1010);
    drive_symbol(400, 400);
    idle(1);
    wait_drain("drain_abort");
    check("abort_cnt_one", int'(abort_cnt), 1);
    check("no_overrun_yet", int'(overrun), 0);

    // Backpressure: two held, third dropped.
    @(negedge clk); sym_ready = 1'b0;
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0110);
    drive_symbol(160, -40);
    drive_symbol(-1, 64);
    drive_symbol(400, 400);
    idle(4);
    #1;
    check("ovr_flag",  int'(overrun),   1);
    check("ovr_valid", int'(sym_valid), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("hold_data", int'(sym_data), 4'b1001);
    end
    @(negedge clk); sym_ready = 1'b1;
    wait_drain("drain_overrun");
    check("ovr_empty_after", int'(sym_valid), 0);

    // Reset mid-symbol.
    drive_sample(50, -50);
    drive_sample(50, -50);
    drive_sample(50, -50);
    @(negedge clk); dm.valid = 1'b0; rstn = 1'b0; #1;
    check("mid_rst_valid",   int'(sym_valid), 0);
    check("mid_rst_data",    int'(sym_data),  0);
    check("mid_rst_abort",   int'(abort_cnt), 0);
    check("mid_rst_overrun", int'(overrun),   0);
    @(negedge clk); rstn = 1'b1;
    exp_q.push_back(4'b1000);
    drive_symbol(200, -200);
    idle(2);
    wait_drain("drain_post_reset");
    idle(8);
    check("post_rst_abort", int'(abort_cnt), 0);

    // abort_cnt saturation.
    for (int k = 0; k < 260; k++) begin
      drive_sample(1, 1);
      idle(1);
    end
    idle(2);
    check("abort_sat", int'(abort_cnt), 255);
    check("abort_no_sym", int'(sym_valid), 0);

    idle(5);
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
